// File: rtl/step_request_if.sv
// Button front-end bus: raw step button in, clean step request, held
// system reset and step counter out.
interface step_request_if;
    logic       btn_raw;
    logic       step_n;
    logic       sys_n_reset;
    logic [7:0] step_cnt;

    // Button / consumer side: drives the raw button, observes the outputs.
    modport master (
        output btn_raw,
        input  step_n,
        input  sys_n_reset,
        input  step_cnt
    );

    // The step_request block itself.
    modport slave (
        input  btn_raw,
        output step_n,
        output sys_n_reset,
        output step_cnt
    );
endinterface

// File: rtl/step_request.sv
// step_request: synchronises and debounces the active-low step button,
// emits one-cycle active-low step requests and produces a delayed, held
// system reset. Optional auto-repeat while held: STEP_AUTOREPEAT_EN.
module step_request #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_PERIOD   = 2000000,
    parameter int RESET_HOLD      = 16
) (
    input  logic           clk_x2,
    input  logic           n_reset,
    step_request_if.slave  bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

`ifdef STEP_AUTOREPEAT_EN
    localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TM_W   = $clog2(TM_MAX + 1);
    localparam logic [TM_W-1:0] DELAY_LAST  = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] PERIOD_LAST = TM_W'(REPEAT_PERIOD - 1);
    localparam logic [TM_W-1:0] TM_ONE      = TM_W'(1);
`else
    // The repeat parameters stay on the port list so both builds share one
    // instantiation; nothing is built from them here.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 4) begin : g_repeat_params_unused
    end
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
`ifdef STEP_AUTOREPEAT_EN
        ,
        REPEAT
`endif
    } state_t;

    logic              sync1_reg;
    logic              btn_s;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              sys_n_reset_reg;

    state_t            state_reg, state_next;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    logic              step_n_reg, step_n_next;
    logic [7:0]        step_cnt_reg, step_cnt_next;
    logic              pulse;
`ifdef STEP_AUTOREPEAT_EN
    logic [TM_W-1:0]   timer_reg, timer_next;
`endif

    // Two-flop synchroniser; the only sampler of the raw button.
    always_ff @(posedge clk_x2) begin
        if (!n_reset) begin
            sync1_reg <= 1'b1;
            btn_s     <= 1'b1;
        end else begin
            sync1_reg <= bus.btn_raw;
            btn_s     <= sync1_reg;
        end
    end

    // Hold the system reset low for RESET_HOLD edges after n_reset releases.
    always_ff @(posedge clk_x2) begin
        if (!n_reset) begin
            hold_cnt_reg    <= '0;
            sys_n_reset_reg <= 1'b0;
        end else if (!sys_n_reset_reg) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_ONE;
            if (hold_cnt_reg == HOLD_LAST) begin
                sys_n_reset_reg <= 1'b1;
            end
        end
    end

    // FSM and counter state register.
    always_ff @(posedge clk_x2) begin
        if (!n_reset) begin
            state_reg    <= IDLE;
            db_cnt_reg   <= '0;
            step_n_reg   <= 1'b1;
            step_cnt_reg <= '0;
`ifdef STEP_AUTOREPEAT_EN
            timer_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            db_cnt_reg   <= db_cnt_next;
            step_n_reg   <= step_n_next;
            step_cnt_reg <= step_cnt_next;
`ifdef STEP_AUTOREPEAT_EN
            timer_reg    <= timer_next;
`endif
        end
    end

    // Next-state: debounce press/release, step pulses, optional auto-repeat.
    always_comb begin
        state_next    = state_reg;
        db_cnt_next   = db_cnt_reg;
        step_n_next   = 1'b1;
        step_cnt_next = step_cnt_reg;
        pulse         = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
        timer_next    = timer_reg;
`endif
        if (!sys_n_reset_reg) begin
            // Rest of the design is still in reset: stay parked and cleared.
            state_next    = IDLE;
            db_cnt_next   = '0;
            step_cnt_next = '0;
`ifdef STEP_AUTOREPEAT_EN
            timer_next    = '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!btn_s) begin
                        state_next  = PRESS_DB;
                        db_cnt_next = DB_ONE;
                    end
                end
                PRESS_DB: begin
                    if (btn_s) begin
                        state_next = IDLE;
                    end else if (db_cnt_reg == DB_LAST) begin
                        pulse      = 1'b1;
                        state_next = HELD;
`ifdef STEP_AUTOREPEAT_EN
                        timer_next = '0;
`endif
                    end else begin
                        db_cnt_next = db_cnt_reg + DB_ONE;
                    end
                end
                HELD: begin
                    if (btn_s) begin
                        state_next  = RELEASE_DB;
                        db_cnt_next = DB_ONE;
`ifdef STEP_AUTOREPEAT_EN
                    end else if (timer_reg == DELAY_LAST) begin
                        pulse      = 1'b1;
                        state_next = REPEAT;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + TM_ONE;
`endif
                    end
                end
`ifdef STEP_AUTOREPEAT_EN
                REPEAT: begin
                    if (btn_s) begin
                        state_next  = RELEASE_DB;
                        db_cnt_next = DB_ONE;
                    end else if (timer_reg == PERIOD_LAST) begin
                        pulse      = 1'b1;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + TM_ONE;
                    end
                end
`endif
                RELEASE_DB: begin
                    // Any low sample restarts the release window; no step here.
                    if (!btn_s) begin
                        db_cnt_next = '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_next = IDLE;
                    end else begin
                        db_cnt_next = db_cnt_reg + DB_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (pulse) begin
                step_n_next   = 1'b0;
                step_cnt_next = step_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.step_n      = step_n_reg;
    assign bus.sys_n_reset = sys_n_reset_reg;
    assign bus.step_cnt    = step_cnt_reg;

endmodule
